// File: rtl/base_endian_swap_pipe.sv
// base_endian_swap_pipe: per-beat byte-order swap with an output register and skid register.
module base_endian_swap_pipe #(
  parameter int bytes = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               i_v,
  output logic               i_r,
  input  logic [8*bytes-1:0] i_d,
  input  logic [bytes-1:0]   i_be,
  input  logic [1:0]         i_mode,
  output logic               o_v,
  input  logic               o_r,
  output logic [8*bytes-1:0] o_d,
  output logic [bytes-1:0]   o_be
);
  localparam int W = 8 * bytes;
  typedef enum logic [1:0] {EMPTY, ONE, FULL} st_e;
  st_e st_q, st_d;
  logic [W-1:0] p1, p2, p3, sw_dat, dat_q, dat_d, sdat_q;
  logic [bytes-1:0] b1, b2, b3, sw_be, be_q, be_d, sbe_q;
  logic ir_q, in_x, out_x, or_ld, sr_ld, sr_mv;
  // Byte 0 is the most significant byte of the bus, so byte k sits at bits 8*(bytes-1-k)
  for (genvar k = 0; k < bytes; k++) begin : g_perm
    localparam int S1 = bytes - 1 - k;
    localparam int S2 = 4 * (k / 4) + 3 - k % 4;
    localparam int S3 = 2 * (k / 2) + 1 - k % 2;
    assign p1[8*(bytes-1-k) +: 8] = i_d[8*(bytes-1-S1) +: 8];
    assign p2[8*(bytes-1-k) +: 8] = i_d[8*(bytes-1-S2) +: 8];
    assign p3[8*(bytes-1-k) +: 8] = i_d[8*(bytes-1-S3) +: 8];
    assign b1[bytes-1-k] = i_be[bytes-1-S1];
    assign b2[bytes-1-k] = i_be[bytes-1-S2];
    assign b3[bytes-1-k] = i_be[bytes-1-S3];
  end
  assign sw_dat = i_mode == 2'd0 ? i_d  : i_mode == 2'd1 ? p1 : i_mode == 2'd2 ? p2 : p3;
  assign sw_be  = i_mode == 2'd0 ? i_be : i_mode == 2'd1 ? b1 : i_mode == 2'd2 ? b2 : b3;
  assign o_v   = st_q != EMPTY;
  assign i_r   = ir_q;
  assign o_d   = dat_q;
  assign o_be  = be_q;
  assign in_x  = i_v & ir_q;
  assign out_x = o_v & o_r;
  assign or_ld = in_x & (st_q == EMPTY | out_x);
  assign sr_ld = in_x & st_q == ONE & !out_x;
  assign sr_mv = st_q == FULL & out_x;
  always_comb begin
    st_d = st_q;
    case (st_q)
      EMPTY:   st_d = in_x ? ONE : EMPTY;
      ONE:     st_d = (in_x & !out_x) ? FULL : (!in_x & out_x) ? EMPTY : ONE;
      FULL:    st_d = out_x ? ONE : FULL;
      default: st_d = EMPTY;
    endcase
    dat_d = sr_mv ? sdat_q : or_ld ? sw_dat : dat_q;
    be_d  = sr_mv ? sbe_q  : or_ld ? sw_be  : be_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      st_q  <= EMPTY;
      ir_q  <= 1'b0;
      dat_q <= '0;
      be_q  <= '0;
    end else begin
      st_q  <= st_d;
      ir_q  <= st_d != FULL;
      dat_q <= dat_d;
      be_q  <= be_d;
    end
  end
  always_ff @(posedge clk) begin
    if (sr_ld) begin
      sdat_q <= sw_dat;
      sbe_q  <= sw_be;
    end
  end
endmodule
